// File: rtl/debug_slave_cmd_queue.sv
// Purpose: clk-side JTAG debug slave. Synchronises the update-IR/DR strobes, queues scans, decodes them into action pulses.
// Latency: strobe rise to pulse is SYNC_STAGES+1 edges; push one edge later; pop to jdo/take_* is 1 cycle.
// Backpressure: head is held until cmd_ready; a push into a full queue without a pop is dropped (sticky overflow).
// Optional feature macro: DBG_CMD_PARITY_EN (even-parity check on sr[SR_W-1], adds sticky parity_err output).
module debug_slave_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = 34,
  localparam int NUM_CH     = 2**IR_W,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic              cmd_ready,
  input  logic              clr_err,
  output logic              cmd_valid,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
`ifdef DBG_CMD_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } cmd_t;

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic                   uir_last, udr_last;
  logic                   uir_p, udr_p;
  logic [IR_W-1:0]        ir_q;

  cmd_t                   mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       count;
  cmd_t                   head;
  logic                   parity_ok, push_req, push, pop, full, drop;
  logic [NUM_CH-1:0]      head_oh;

  // Synchronise both strobes and register exactly one pulse per rising edge of the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_last <= 1'b0;
      udr_last <= 1'b0;
      uir_p    <= 1'b0;
      udr_p    <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_last <= uir_sync[SYNC_STAGES-1];
      udr_last <= udr_sync[SYNC_STAGES-1];
      uir_p    <= uir_sync[SYNC_STAGES-1] & ~uir_last;
      udr_p    <= udr_sync[SYNC_STAGES-1] & ~udr_last;
    end
  end

  // Capture the instruction; a push in the same cycle still sees the previous value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir_q <= '0;
    else if (uir_p) ir_q <= ir_in;
  end

`ifdef DBG_CMD_PARITY_EN
  assign parity_ok = ~(^sr);
`else
  assign parity_ok = 1'b1;
`endif

  assign head      = mem[rd_ptr];
  assign head_oh   = NUM_CH'(1) << head.ir;
  assign cmd_valid = (count != '0);
  assign level     = count;
  assign full      = (count == LVL_W'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  assign push_req  = udr_p & parity_ok;
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  // Queue storage; entries are only read when the pointers say they are valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_q, sr};
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Decode the popped head into jdo and a one-cycle one-hot action/no-action pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= head.sr;
        if (head.sr[ACT_BIT]) take_action    <= head_oh;
        else                  take_no_action <= head_oh;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_err keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

`ifdef DBG_CMD_PARITY_EN
  // Sticky parity error; bad-parity scans never reach the queue so never count as overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 parity_err <= 1'b0;
    else if (udr_p & ~parity_ok)  parity_err <= 1'b1;
    else if (clr_err)             parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Bench for debug_slave_cmd_queue: directed scans, scoreboard of expected pulses/jdo, sticky flags and reset.
// Expected pulses are queued when a scan is driven and compared when take_action/take_no_action fire.
// Build with DBG_CMD_PARITY_EN defined to include the parity checks.
module tb_debug_slave_cmd_queue;
  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int NCH  = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vs_uir, vs_udr, cmd_ready, clr_err;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            cmd_valid, overflow;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action, take_no_action;
  logic [2:0]      level;
`ifdef DBG_CMD_PARITY_EN
  logic            parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [2*NCH+SR_W-1:0] exp_q [$];

  debug_slave_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .clr_err(clr_err),
    .cmd_valid(cmd_valid), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .level(level), .overflow(overflow)
`ifdef DBG_CMD_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scan register with act bit, a tag in the low bits and (when enabled) a correct even-parity top bit.
  function automatic logic [SR_W-1:0] mk_sr(input logic act, input logic [31:0] tag);
    logic [SR_W-1:0] s;
    s = '0;
    s[31:0] = tag;
    s[35]   = tag[0];
    s[34]   = act;
`ifdef DBG_CMD_PARITY_EN
    s[SR_W-1] = ^s[SR_W-2:0];
`else
    s[SR_W-1] = tag[1];
`endif
    return s;
  endfunction

  function automatic logic [2*NCH+SR_W-1:0] mk_exp(input logic [IR_W-1:0] ch, input logic [SR_W-1:0] s);
    logic [NCH-1:0] oh;
    oh = 4'b0001 << ch;
    return s[34] ? {oh, 4'b0000, s} : {4'b0000, oh, s};
  endfunction

  // Scoreboard: every pulse must match the oldest expected command.
  always @(negedge clk) begin
    if (reset_n && ((take_action | take_no_action) != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'({take_action, take_no_action}), 64'd0);
      end else begin
        check("sb_pulse_jdo", 64'({take_action, take_no_action, jdo}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_ir(input logic [IR_W-1:0] v);
    @(negedge clk); ir_in = v; vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan(input logic [SR_W-1:0] v, input logic [IR_W-1:0] ch, input bit expect_push, input int hold);
    @(negedge clk); sr = v; vs_udr = 1'b1;
    if (expect_push) exp_q.push_back(mk_exp(ch, v));
    repeat (hold) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    cmd_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    check(tag, 64'(level), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [SR_W-1:0] v;
    reset_n = 1'b0; vs_uir = 0; vs_udr = 0; cmd_ready = 0; clr_err = 0;
    ir_in = '0; sr = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;

    // Single action command on channel 1, pulse SYNC_STAGES+3 cycles after the udr rise.
    set_ir(2'd1);
    @(negedge clk);
    v = mk_sr(1'b1, 32'h0000_0011);
    sr = v; cmd_ready = 1'b1; vs_udr = 1'b1;
    exp_q.push_back(mk_exp(2'd1, v));
    repeat (4) @(negedge clk);
    check("t1_no_early_pulse", 64'(take_action), 64'd0);
    @(negedge clk);
    check("t1_take_action", 64'(take_action), 64'b0010);
    check("t1_jdo", 64'(jdo), 64'(v));
    repeat (3) @(negedge clk);
    vs_udr = 1'b0; cmd_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_jdo_held", 64'(jdo), 64'(v));

    // Four no-action scans queued, then drained back to back.
    for (int i = 0; i < 4; i++) begin
      set_ir(2'(i));
      scan(mk_sr(1'b0, 32'h100 + 32'(i)), 2'(i), 1'b1, 4);
    end
    check("t2_level_full", 64'(level), 64'd4);
    check("t2_cmd_valid", 64'(cmd_valid), 64'd1);
    check("t2_no_pulse", 64'({take_action, take_no_action}), 64'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_tna_%0d", i), 64'(take_no_action), 64'(4'b0001 << i));
    end
    cmd_ready = 1'b0;
    @(negedge clk);
    check("t2_level_empty", 64'(level), 64'd0);

    // Overflow: fifth scan into a full queue is dropped, clr_err clears the flag.
    set_ir(2'd3);
    for (int i = 0; i < 4; i++) scan(mk_sr(i[0], 32'h200 + 32'(i)), 2'd3, 1'b1, 4);
    scan(mk_sr(1'b1, 32'h2ff), 2'd3, 1'b0, 4);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_level", 64'(level), 64'd4);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("t3_overflow_clr", 64'(overflow), 64'd0);
    drain("t3_drain");

    // Full queue, fifth push coincides with a pop: accepted, level stays at DEPTH.
    set_ir(2'd2);
    for (int i = 1; i <= 4; i++) scan(mk_sr(i[0], 32'h300 + 32'(i)), 2'd2, 1'b1, 4);
    @(negedge clk);
    v = mk_sr(1'b1, 32'h305);
    sr = v; vs_udr = 1'b1;
    exp_q.push_back(mk_exp(2'd2, v));
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("t4_level_stays", 64'(level), 64'd4);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    drain("t4_drain");

    // Long udr level gives one push; async reset discards the queue.
    scan(mk_sr(1'b0, 32'h400), 2'd2, 1'b0, 20);
    check("t5_one_push", 64'(level), 64'd1);
    scan(mk_sr(1'b0, 32'h401), 2'd2, 1'b0, 4);
    scan(mk_sr(1'b1, 32'h402), 2'd2, 1'b0, 4);
    check("t5_level3", 64'(level), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_level", 64'(level), 64'd0);
    check("t5_async_valid", 64'(cmd_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_after_release", 64'({take_action, take_no_action, level}), 64'd0);
    cmd_ready = 1'b0;

`ifdef DBG_CMD_PARITY_EN
    // Bad parity is rejected without touching overflow.
    v = mk_sr(1'b1, 32'h500);
    v[0] = ~v[0];
    scan(v, 2'd0, 1'b0, 4);
    check("t6_no_push", 64'(level), 64'd0);
    check("t6_parity_err", 64'(parity_err), 64'd1);
    check("t6_overflow", 64'(overflow), 64'd0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("t6_parity_clr", 64'(parity_err), 64'd0);
    scan(mk_sr(1'b1, 32'h501), 2'd0, 1'b1, 4);
    check("t6_good_push", 64'(level), 64'd1);
    drain("t6_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
